// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage -- radix-2 single-path delay-feedback (SDF) butterfly stage.
//
// Accepts one complex sample per i_valid cycle and pairs samples D apart
// through a D-deep complex feedback delay line. Per 2D-sample block, it emits
// D sums (second half of block k) and then D differences (first half of
// block k+1), in natural stream order.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_valid      input qualifier, one sample accepted per high cycle
//   i_re, i_im   input sample, two's complement, `W bits each
//   o_valid      registered output qualifier (latency 1)
//   o_re, o_im   registered output sample, held while o_valid is low
//   o_sum        1 = output is a sum, 0 = output is a difference
//
// Configuration:
//   `W               data width; defaults to 16 when not predefined
//                    (normally supplied by width.vh)
//   SDF_BF_SCALE_EN  when defined, sums and differences are arithmetic-shifted
//                    right by one (truncating), so they cannot overflow;
//                    otherwise they wrap modulo 2^W

`ifndef W
`define W 16
`endif

module sdf_r2_stage #(
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  input  logic [`W-1:0]  i_re,
  input  logic [`W-1:0]  i_im,
  output logic           o_valid,
  output logic [`W-1:0]  o_re,
  output logic [`W-1:0]  o_im,
  output logic           o_sum
);

  localparam int DW = `W;
  localparam int CW = $clog2(2 * D);
  localparam logic [CW-1:0] HALF = CW'(D);

  // Bring a W+1-bit sum or difference back to W bits. The same reduction
  // is used for the output path and for the delay-line path.
  function automatic logic [DW-1:0] reduce(input logic [DW:0] s);
`ifdef SDF_BF_SCALE_EN
    reduce = s[DW:1];
`else
    reduce = s[DW-1:0];
`endif
  endfunction

  logic [CW-1:0] cnt_r;
  logic          primed_r;
  logic [DW-1:0] dl_re_r [D];
  logic [DW-1:0] dl_im_r [D];

  logic [DW-1:0] f_re_s, f_im_s;
  logic [DW:0]   sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic          fill_s, out_en_s;
  logic [DW-1:0] din_re_s, din_im_s, out_re_s, out_im_s;

  assign f_re_s = dl_re_r[D-1];
  assign f_im_s = dl_im_r[D-1];

  // Butterfly arithmetic and phase-dependent selection of delay input/output.
  always_comb begin
    sum_re_s = {f_re_s[DW-1], f_re_s} + {i_re[DW-1], i_re};
    sum_im_s = {f_im_s[DW-1], f_im_s} + {i_im[DW-1], i_im};
    dif_re_s = {f_re_s[DW-1], f_re_s} - {i_re[DW-1], i_re};
    dif_im_s = {f_im_s[DW-1], f_im_s} - {i_im[DW-1], i_im};
    // 2D is a power of two, so the counter MSB marks the butterfly half.
    fill_s   = ~cnt_r[CW-1];
    out_en_s = i_valid & (~fill_s | primed_r);
    if (fill_s) begin
      din_re_s = i_re;
      din_im_s = i_im;
      out_re_s = f_re_s;
      out_im_s = f_im_s;
    end else begin
      din_re_s = reduce(dif_re_s);
      din_im_s = reduce(dif_im_s);
      out_re_s = reduce(sum_re_s);
      out_im_s = reduce(sum_im_s);
    end
  end

  // Block counter, primed flag and feedback delay line; all frozen on gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      primed_r <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dl_re_r[i] <= '0;
        dl_im_r[i] <= '0;
      end
    end else if (i_valid) begin
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == HALF) begin
        primed_r <= 1'b1;
      end else begin
        primed_r <= primed_r;
      end
      dl_re_r[0] <= din_re_s;
      dl_im_r[0] <= din_im_s;
      for (int i = 1; i < D; i++) begin
        dl_re_r[i] <= dl_re_r[i-1];
        dl_im_r[i] <= dl_im_r[i-1];
      end
    end else begin
      cnt_r    <= cnt_r;
      primed_r <= primed_r;
    end
  end

  // Registered outputs; data and o_sum hold whenever nothing valid is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
      o_sum   <= 1'b0;
    end else if (out_en_s) begin
      o_valid <= 1'b1;
      o_re    <= out_re_s;
      o_im    <= out_im_s;
      o_sum   <= ~fill_s;
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed self-checking bench for sdf_r2_stage with W = 16, D = 4.
`ifndef W
`define W 16
`endif

module tb_sdf_r2_stage;

  localparam int DW = `W;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_re, i_im;
  logic          o_valid;
  logic [DW-1:0] o_re, o_im;
  logic          o_sum;

  int checks;
  int failures;

  logic [DW-1:0] e_re, e_im;
  logic          e_sum;

  sdf_r2_stage #(.D(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_re    (i_re),
    .i_im    (i_im),
    .o_valid (o_valid),
    .o_re    (o_re),
    .o_im    (o_im),
    .o_sum   (o_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sc(input int v);
`ifdef SDF_BF_SCALE_EN
    sc = v >>> 1;
`else
    sc = v;
`endif
  endfunction

  task automatic check_all(input string tag, input logic ev);
    checks++;
    assert (o_valid === ev) else begin
      failures++;
      $error("FAIL %s valid: got %b expected %b", tag, o_valid, ev);
    end
    checks++;
    assert (o_re === e_re) else begin
      failures++;
      $error("FAIL %s re: got %0d expected %0d", tag, $signed(o_re), $signed(e_re));
    end
    checks++;
    assert (o_im === e_im) else begin
      failures++;
      $error("FAIL %s im: got %0d expected %0d", tag, $signed(o_im), $signed(e_im));
    end
    checks++;
    assert (o_sum === e_sum) else begin
      failures++;
      $error("FAIL %s sum: got %b expected %b", tag, o_sum, e_sum);
    end
  endtask

  // One clock: drive inputs, sample #1 after the edge. When no valid output
  // is expected, the previously expected data must still be held.
  task automatic step(input string tag, input logic v, input int re, input int im,
                      input logic ev, input int ere, input int eim, input logic es);
    i_valid = v;
    i_re    = DW'(re);
    i_im    = DW'(im);
    @(posedge clk);
    #1;
    if (ev) begin
      e_re  = DW'(ere);
      e_im  = DW'(eim);
      e_sum = es;
    end
    check_all(tag, ev);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_re    = '0;
    i_im    = '0;
    e_re    = '0;
    e_im    = '0;
    e_sum   = 1'b0;
    #1;
    check_all("reset", 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Samples n = 1..8 with re = rb*n, im = ib*n, optional idle cycle after
  // each, then four zero samples to flush the differences.
  task automatic feed_block(input string tag, input int rb, input int ib, input bit gaps);
    for (int n = 1; n <= 8; n++) begin
      if (n <= 4)
        step(tag, 1'b1, rb * n, ib * n, 1'b0, 0, 0, 1'b0);
      else
        step(tag, 1'b1, rb * n, ib * n, 1'b1, sc(rb * (2 * n - 4)), sc(ib * (2 * n - 4)), 1'b1);
      if (gaps) step({tag, "_gap"}, 1'b0, 99, 99, 1'b0, 0, 0, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      step(tag, 1'b1, 0, 0, 1'b1, sc(-4 * rb), sc(-4 * ib), 1'b0);
      if (gaps) step({tag, "_gap"}, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    do_reset();
    feed_block("basic", 1, 0, 1'b0);

    do_reset();
    feed_block("gaps", 1, 0, 1'b1);

    // Mid-block reset after 6 samples, then an exact replay.
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      if (n <= 4) step("pre_rst", 1'b1, n, 0, 1'b0, 0, 0, 1'b0);
      else        step("pre_rst", 1'b1, n, 0, 1'b1, sc(2 * n - 4), 0, 1'b1);
    end
    do_reset();
    feed_block("replay", 1, 0, 1'b0);

    do_reset();
    feed_block("complex", 0, 10, 1'b0);

    // Overflow: a = b = 0x7FFF.
    do_reset();
    for (int n = 0; n < 4; n++) step("ovf_fill", 1'b1, 32'h7FFF, 0, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 4; n++) begin
`ifdef SDF_BF_SCALE_EN
      step("ovf_sum", 1'b1, 32'h7FFF, 0, 1'b1, 32'h7FFF, 0, 1'b1);
`else
      step("ovf_sum", 1'b1, 32'h7FFF, 0, 1'b1, 32'hFFFE, 0, 1'b1);
`endif
    end
    for (int n = 0; n < 4; n++) step("ovf_dif", 1'b1, 0, 0, 1'b1, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdf_r2_stage.md
# sdf_r2_stage

Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath. Takes one complex sample per valid cycle, pairs samples D apart through an internal D-deep feedback delay line, and emits sums then differences in natural stream order. It consumes the same `W`-bit complex sample stream as the 4-deep delay chain and feeds the downstream twiddle/next stage.

## Interface
Parameters:
- `D`, default 4: butterfly span and feedback depth; power of two, at least 2.
- Data width: `` `W `` from `width.vh`; not a parameter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input sample qualifier; one sample accepted per cycle when high.
- `i_re`, `i_im`  in  `W` each  input sample, two's complement.
- `o_valid`  out  1  output sample qualifier.
- `o_re`, `o_im`  out  `W` each  output sample, two's complement.
- `o_sum`  out  1  high when the current output is a sum (first half of a block), low when it is a difference.

## Operation
- `cnt` is a log2(2D)-bit counter that advances only on `i_valid` and wraps 2D-1 to 0. No backpressure; gaps in `i_valid` freeze all state (delay line, `cnt`, `primed`).
- Feedback delay: a D-entry complex shift register that shifts only on `i_valid`. Its tail `f` is the value written D accepted samples earlier.
- Fill phase (`cnt < D`):
  - Delay input = `x`.
  - Output = `f`, the difference stored in the previous block; `o_sum` = 0.
- Butterfly phase (`cnt >= D`):
  - `a` = `f` (sample n), `b` = `x` (sample n+D).
  - Output = a+b, `o_sum` = 1.
  - Delay input = a-b.
- Arithmetic: sum and difference are computed at `W`+1 bits per component, then reduced to `W` bits per the Configuration section. Differences are reduced the same way before entering the delay line.
- `primed`: cleared by reset, set on the first accepted sample with `cnt == D`, and held until reset.
  - Fill-phase outputs are valid only when `primed` = 1.
  - Butterfly-phase outputs are always valid.
- Output order per block: D sums (during block k's second half), then D differences (during block k+1's first half).
- Flushing the last block's differences requires D further valid inputs; zeros are acceptable.

## Timing
- Outputs are registered, with latency 1 cycle from the accepting `i_valid` edge.
- `o_valid` = the previous cycle's `i_valid` AND (`cnt` was ≥ D OR `primed`).
- When `o_valid` = 0, `o_re`, `o_im` and `o_sum` hold their last values.
- Reset values: `o_valid` = 0, `o_re` = 0, `o_im` = 0, `o_sum` = 0. `cnt`, `primed` and all delay entries are also 0.
- Reset mid-block discards partial data. After release, the first D valid inputs produce no output.
- `cnt` wrap and a `primed` set in the same cycle need no special handling; they never coincide, since `primed` sets at `cnt == D`.
- Throughput: 1 sample per cycle sustained, with no bubbles inserted.

## Configuration
- Macro `SDF_BF_SCALE_EN`.
  - Defined: every sum and difference is arithmetic-shifted right by 1 after the `W`+1-bit add, dropping the LSB (truncation, no rounding). Overflow cannot occur.
  - Undefined: the low `W` bits are kept, so overflow wraps modulo 2^`W`.
- The reduction is identical for the output path and the delay-line path.

## Test plan
All scenarios use `W` = 16, D = 4, no scaling unless stated, and `i_im` = 0 unless stated.
- Basic block: `i_re` = 1..8 continuous, then 4 zeros.
  - No output for the first 4 inputs.
  - Then `o_re` = 6, 8, 10, 12 with `o_sum` = 1.
  - Then -4, -4, -4, -4 with `o_sum` = 0; `o_valid` high for 8 cycles.
- Scaling (`SDF_BF_SCALE_EN` defined), same stimulus: `o_re` = 3, 4, 5, 6, then -2 ×4.
- Overflow: `a` = `b` = 0x7FFF. Unscaled sum = 0xFFFE; scaled sum = 0x7FFF. Difference = 0 in both cases.
- Gaps: `i_valid` toggled 1-0-1-0 with data 1..8 gives the same output sequence as the basic block, spaced by the gaps.
- Mid-block reset: pulse `rst_n` low after 6 samples. Outputs drop to 0 asynchronously. Replaying 1..8 reproduces the basic-block result exactly.
- Complex data: `i_im` = 10·n, `i_re` = 0 for n = 1..8.
  - `o_im` sums = 60, 80, 100, 120.
  - `o_im` differences = -40 ×4.
  - `o_re` stays 0 throughout.
